// File: rtl/seq_gen_if.sv
// ---------------------------------------------------------------------------
// seq_gen_if
//   Bundle of the request/stream signals between a pattern requester
//   (master) and the seq_gen serial transmitter (slave).
//
//   Optional feature macro: SEQ_GEN_REPEAT_EN adds the reps field.
//
//   Signals:
//     start    master->slave  request to transmit a pattern
//     pattern  master->slave  WIDTH-bit word, sent MSB first
//     reps     master->slave  extra repetitions (SEQ_GEN_REPEAT_EN only)
//     x        slave->master  serial data bit, 0 when idle
//     x_valid  slave->master  x carries a pattern bit
//     busy     slave->master  frame in progress (through the DONE cycle)
//     done     slave->master  one-cycle pulse after the last bit
// ---------------------------------------------------------------------------
interface seq_gen_if #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
);

  logic             start;
  logic [WIDTH-1:0] pattern;
`ifdef SEQ_GEN_REPEAT_EN
  logic [REP_W-1:0] reps;
`endif
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;

  // Reject unusable sizes at elaboration.
  if (WIDTH < 2 || WIDTH > 32 || REP_W < 1) begin : g_param_err
    $error("seq_gen_if: WIDTH must be 2..32 and REP_W >= 1");
  end

`ifdef SEQ_GEN_REPEAT_EN
  modport master (output start, output pattern, output reps,
                  input x, input x_valid, input busy, input done);
  modport slave  (input start, input pattern, input reps,
                  output x, output x_valid, output busy, output done);
`else
  modport master (output start, output pattern,
                  input x, input x_valid, input busy, input done);
  modport slave  (input start, input pattern,
                  output x, output x_valid, output busy, output done);
`endif

endinterface

// File: rtl/seq_gen.sv
// ---------------------------------------------------------------------------
// seq_gen
//   Serial pattern transmitter. On an accepted start the WIDTH-bit pattern
//   is shifted out MSB first, one bit per clk, qualified by x_valid. busy
//   covers the whole frame plus the DONE cycle; done pulses once after the
//   last bit. Requests arriving while busy are ignored.
//
//   Optional feature macro: SEQ_GEN_REPEAT_EN
//     defined   : reps port present; pattern is sent reps+1 times with no gap
//     undefined : every frame is exactly WIDTH bits
//
//   Ports:
//     clk  input  clock, rising edge active
//     rst  input  asynchronous active-high reset
//     bus  seq_gen_if.slave  start/pattern(/reps) in, x/x_valid/busy/done out
// ---------------------------------------------------------------------------
module seq_gen #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
) (
  input  logic      clk,
  input  logic      rst,
  seq_gen_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Reject unusable sizes at elaboration.
  if (WIDTH < 2 || WIDTH > 32 || REP_W < 1) begin : g_param_err
    $error("seq_gen: WIDTH must be 2..32 and REP_W >= 1");
  end

  state_t           state_r, state_s;
  logic [WIDTH-1:0] shift_r, shift_s;
  logic [CW-1:0]    bitcnt_r, bitcnt_s;
`ifdef SEQ_GEN_REPEAT_EN
  logic [WIDTH-1:0] copy_r, copy_s;
  logic [REP_W-1:0] repcnt_r, repcnt_s;
`endif
  logic             x_r, x_s;
  logic             x_valid_r, x_valid_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;

  // Next-state and next-output logic for the transmit FSM.
  always_comb begin
    state_s   = state_r;
    shift_s   = shift_r;
    bitcnt_s  = bitcnt_r;
`ifdef SEQ_GEN_REPEAT_EN
    copy_s    = copy_r;
    repcnt_s  = repcnt_r;
`endif
    x_s       = 1'b0;
    x_valid_s = 1'b0;
    busy_s    = 1'b0;
    done_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          shift_s   = bus.pattern;
          bitcnt_s  = CW'(WIDTH - 1);
`ifdef SEQ_GEN_REPEAT_EN
          copy_s    = bus.pattern;
          repcnt_s  = bus.reps;
`endif
          state_s   = ST_SHIFT;
          x_s       = bus.pattern[WIDTH-1];
          x_valid_s = 1'b1;
          busy_s    = 1'b1;
        end else begin
          state_s   = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        busy_s = 1'b1;
        if (bitcnt_r != {CW{1'b0}}) begin
          // Rotate rather than zero-fill: the bit shifted in is never
          // transmitted, and rotating keeps every register bit in use.
          shift_s   = {shift_r[WIDTH-2:0], shift_r[WIDTH-1]};
          x_s       = shift_r[WIDTH-2];
          x_valid_s = 1'b1;
          bitcnt_s  = bitcnt_r - CW'(1);
`ifdef SEQ_GEN_REPEAT_EN
        end else if (repcnt_r != {REP_W{1'b0}}) begin
          // Back-to-back repeat: reload from the captured copy, no gap cycle.
          shift_s   = copy_r;
          x_s       = copy_r[WIDTH-1];
          x_valid_s = 1'b1;
          bitcnt_s  = CW'(WIDTH - 1);
          repcnt_s  = repcnt_r - REP_W'(1);
`endif
        end else begin
          state_s   = ST_DONE;
          done_s    = 1'b1;
        end
      end

      ST_DONE: begin
        // start is deliberately not looked at here.
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      shift_r   <= {WIDTH{1'b0}};
      bitcnt_r  <= {CW{1'b0}};
`ifdef SEQ_GEN_REPEAT_EN
      copy_r    <= {WIDTH{1'b0}};
      repcnt_r  <= {REP_W{1'b0}};
`endif
      x_r       <= 1'b0;
      x_valid_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      shift_r   <= shift_s;
      bitcnt_r  <= bitcnt_s;
`ifdef SEQ_GEN_REPEAT_EN
      copy_r    <= copy_s;
      repcnt_r  <= repcnt_s;
`endif
      x_r       <= x_s;
      x_valid_r <= x_valid_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  assign bus.x       = x_r;
  assign bus.x_valid = x_valid_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;

endmodule

// File: doc/seq_gen.md
# seq_gen

Serial pattern transmitter that drives the one-bit serial input `x` of the sequence detector. A WIDTH-bit pattern is captured on a start request and shifted out MSB-first, one bit per `clk`, with a valid qualifier, a busy flag and a completion pulse. It sits upstream of the detector in self-checking benches and on-chip stimulus paths. It replaces hand-timed `x` assignments with a cycle-exact, repeatable bit stream.

## Interface

Parameters:
- WIDTH, default 8: pattern length in bits; legal range 2..32.
- REP_W, default 4: width of the repeat-count port. Used only when SEQ_GEN_REPEAT_EN is defined.

Ports:
- clk  input  1  clock; all state changes occur on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request to transmit; sampled on the rising edge only while busy=0.
- pattern  input  WIDTH  word to send; captured on the accepting edge.
- reps  input  REP_W  number of extra repetitions; captured with pattern. Present only with SEQ_GEN_REPEAT_EN.
- x  output  1  serial data; registered; 0 when not transmitting.
- x_valid  output  1  high while x carries a pattern bit.
- busy  output  1  high from the accepting edge through the DONE cycle.
- done  output  1  one-cycle pulse after the last bit.

## Operation

- States: IDLE, SHIFT, DONE. Encoding is free. All outputs come from registers.
- Reset: asynchronous, takes effect immediately, including mid-frame.
  - State goes to IDLE.
  - Shift register, pattern copy, bit counter and repeat counter clear to 0.
  - x=0, x_valid=0, busy=0, done=0.
- IDLE, start=1 at an edge:
  - Load the shift register and the pattern copy with pattern.
  - Set the bit counter to WIDTH-1 and the repeat counter to reps.
  - Go to SHIFT.
  - x=pattern[WIDTH-1], x_valid=1, busy=1.
- SHIFT, at each edge:
  - Bit counter > 0: shift left by one, x takes the new MSB, decrement the bit counter.
  - Bit counter = 0 and repeat counter > 0: reload the shift register from the pattern copy, set the bit counter to WIDTH-1, decrement the repeat counter. x=copy[WIDTH-1]. No gap cycle.
  - Bit counter = 0 and repeat counter = 0: go to DONE. x=0, x_valid=0, done=1, busy stays 1.
- DONE: next edge goes to IDLE with done=0 and busy=0.
- start while busy=1, including the DONE cycle: ignored, with no side effects. pattern and reps are don't-care.
- start held high in IDLE: a new frame is accepted on the first edge where busy=0.
- Counters never wrap. The bit counter is ceil(log2 WIDTH) bits; the repeat counter is REP_W bits.

## Timing

- Start accepted at edge k:
  - bit i (pattern[WIDTH-1-i]) is on x for the cycle after edge k+i, i=0..WIDTH-1.
  - Total x_valid cycles = WIDTH*(reps+1), or WIDTH without the macro.
  - done=1 for the cycle after edge k+WIDTH*(reps+1).
  - busy falls at edge k+WIDTH*(reps+1)+1.
- Minimum start-to-start spacing: WIDTH*(reps+1)+2 edges.
- x changes only on rising edges, so the downstream detector samples a stable bit on the next edge.

## Configuration

- SEQ_GEN_REPEAT_EN defined:
  - The reps port and the repeat counter exist.
  - The pattern is sent reps+1 times back-to-back.
  - reps=0 sends it once.
- SEQ_GEN_REPEAT_EN undefined:
  - No reps port and no repeat counter.
  - Every frame is exactly WIDTH bits; SHIFT goes directly to DONE after bit WIDTH-1.

## Test plan

- Reset: assert rst at t=0, release at t=13 -> x=0, x_valid=0, busy=0, done=0 throughout, even with clk toggling.
- Single frame, WIDTH=8, pattern=8'b01011001, start for one cycle -> x_valid high 8 cycles; x sequence 0,1,0,1,1,0,0,1; done pulse on the 9th cycle; busy low on the 10th.
- start re-asserted with pattern=8'hFF during bits 2..5 and again in the DONE cycle -> stream unchanged, no second frame. Holding start into IDLE launches 8'hFF on the next edge.
- With SEQ_GEN_REPEAT_EN, pattern=8'b10110000, reps=2 -> 24 contiguous valid bits, the pattern three times with no gap; done on cycle 25.
- rst pulsed asynchronously between edges during bit 3 -> all outputs 0 before the next edge, state IDLE. A new start after release sends from bit 0.
- Detector loopback: x drives the detector's serial input with a pattern containing the target sequence -> detector output asserts on the expected cycle. x_valid low outside the frame, x=0.
